ret_addr_stack: RTL

- Return-address stack (RAS) directly downstream of the fetch predecoder.
- Consumes the 4-bit jump-type code per fetched instruction and its PC:
  - pushes PC+4 on calls;
  - pops on returns;
  - supplies the predicted return target to next-PC selection.
- Exports a checkpoint with each op and accepts a restore from the branch-resolution path on mispredict or flush.

---
 rtl/rv64_pred_pkg.sv | 36 +++
 rtl/ret_addr_stack.sv | 134 +++++++++++++
 2 files changed

// File: rtl/rv64_pred_pkg.sv
// Shared branch-prediction definitions for the RV64 fetch front end.
// Holds the predecoder jump-type codes, the internal RAS operation kinds,
// the default RAS geometry and the RAS checkpoint payload.
package rv64_pred_pkg;

  localparam int unsigned RAS_LG_N = 3;
  localparam int unsigned RAS_PC_W = 64;

  // Predecoded control-flow class of a fetched instruction.
  typedef enum logic [3:0] {
    NOT_CFLOW    = 4'd0,
    IS_BR        = 4'd1,
    IS_RET       = 4'd2,
    IS_J         = 4'd3,
    IS_JR        = 4'd4,
    IS_JAL       = 4'd5,
    IS_JALR_CALL = 4'd6,
    IS_POPPUSH   = 4'd7
  } jump_type_e;

  // Stack action implied by a jump type.
  typedef enum logic [1:0] {
    RAS_HOLD    = 2'd0,
    RAS_PUSH    = 2'd1,
    RAS_POP     = 2'd2,
    RAS_POPPUSH = 2'd3
  } ras_op_e;

  // Snapshot carried alongside a predicted op for later repair.
  typedef struct packed {
    logic [RAS_LG_N-1:0] tos;
    logic [RAS_LG_N:0]   cnt;
    logic [RAS_PC_W-1:0] top;
  } ras_ckpt_t;

endpackage

// File: rtl/ret_addr_stack.sv
// Return-address stack fed by the fetch predecoder.
// Calls push PC+4, returns pop, coroutine jumps replace the top entry.
// The top entry is offered combinationally as the return prediction and,
// together with the pointer and occupancy, as a checkpoint for repair.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   fetch_valid/pd/pc          fetched instruction class and PC
//   pred_valid/pred_target     return prediction (stack non-empty / top entry)
//   ckpt_tos/cnt/top           current pointer, occupancy, top entry
//   restore_valid/tos/cnt/top  repair from an earlier checkpoint
//
// Build option: RAS_REPAIR_TOP_EN -- when defined, a restore also rewrites
// the entry at restore_tos with restore_top; otherwise restore_top is unused.
module ret_addr_stack
  import rv64_pred_pkg::*;
#(
  parameter int unsigned LG_N = RAS_LG_N,
  parameter int unsigned PC_W = RAS_PC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  input  logic [3:0]        fetch_pd,
  input  logic [PC_W-1:0]   fetch_pc,
  output logic              pred_valid,
  output logic [PC_W-1:0]   pred_target,
  output logic [LG_N-1:0]   ckpt_tos,
  output logic [LG_N:0]     ckpt_cnt,
  output logic [PC_W-1:0]   ckpt_top,
  input  logic              restore_valid,
  input  logic [LG_N-1:0]   restore_tos,
  input  logic [LG_N:0]     restore_cnt,
  input  logic [PC_W-1:0]   restore_top
);

  localparam int unsigned N     = 1 << LG_N;
  localparam int unsigned CNT_W = LG_N + 1;

  logic [PC_W-1:0]  stk_q [N];
  logic [PC_W-1:0]  stk_d [N];
  logic [LG_N-1:0]  tos_q, tos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PC_W-1:0]  ret_addr;
  logic [LG_N-1:0]  tos_inc;
  logic [LG_N-1:0]  tos_dec;

  // Map a predecoder jump type to the stack action it implies.
  function automatic ras_op_e decode_op(input logic [3:0] pd);
    ras_op_e op;
    op = RAS_HOLD;
    case (jump_type_e'(pd))
      IS_JAL, IS_JALR_CALL: op = RAS_PUSH;
      IS_RET:               op = RAS_POP;
      IS_POPPUSH:           op = RAS_POPPUSH;
      default:              op = RAS_HOLD;
    endcase
    return op;
  endfunction

  assign ret_addr = fetch_pc + PC_W'(4);
  assign tos_inc  = tos_q + LG_N'(1);
  assign tos_dec  = tos_q - LG_N'(1);

  // Next-state: restore beats any same-cycle fetch op, which is dropped.
  always_comb begin
    stk_d = stk_q;
    tos_d = tos_q;
    cnt_d = cnt_q;
    if (restore_valid) begin
      tos_d = restore_tos;
      cnt_d = restore_cnt;
`ifdef RAS_REPAIR_TOP_EN
      stk_d[restore_tos] = restore_top;
`endif
    end else if (fetch_valid) begin
      case (decode_op(fetch_pd))
        RAS_PUSH: begin
          // When full the write lands on the oldest slot; count saturates.
          tos_d          = tos_inc;
          stk_d[tos_inc] = ret_addr;
          if (cnt_q != CNT_W'(N)) cnt_d = cnt_q + CNT_W'(1);
        end
        RAS_POP: begin
          if (cnt_q != '0) begin
            tos_d = tos_dec;
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        RAS_POPPUSH: begin
          stk_d[tos_q] = ret_addr;
          if (cnt_q == '0) cnt_d = CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifndef RAS_REPAIR_TOP_EN
  // restore_top is kept on the interface but has no effect in this build.
  logic unused_restore_top;
  assign unused_restore_top = ^restore_top;
`endif

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(N); i++) stk_q[i] <= '0;
      tos_q <= '0;
      cnt_q <= '0;
    end else begin
      stk_q <= stk_d;
      tos_q <= tos_d;
      cnt_q <= cnt_d;
    end
  end

  // Zero-latency read of the current (pre-update) state.
  assign pred_target = stk_q[tos_q];
  assign ckpt_top    = stk_q[tos_q];
  assign pred_valid  = (cnt_q != '0);
  assign ckpt_tos    = tos_q;
  assign ckpt_cnt    = cnt_q;

`ifndef SYNTHESIS
  // A checkpoint can never hold more entries than the stack has.
  restore_cnt_legal_a: assert property (
    @(posedge clk) disable iff (reset)
    restore_valid |-> (restore_cnt <= CNT_W'(N))
  ) else $error("restore_cnt exceeds stack depth");
`endif

endmodule
